// File: rtl/serial_adder_controller.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder cell; the only adder logic used by the serial engine.
//   Ports:
//     A, B       - operand bits
//     carry_in   - carry into this bit position
//     S          - sum bit
//     carry_out  - carry out of this bit position
// -----------------------------------------------------------------------------
module full_adder (
   input  logic A,
   input  logic B,
   input  logic carry_in,
   output logic S,
   output logic carry_out
);

   logic half_sum;

   always_comb begin
      half_sum  = A ^ B;
      S         = half_sum ^ carry_in;
      carry_out = (A & B) | (carry_in & half_sum);
   end

endmodule

// -----------------------------------------------------------------------------
// serial_adder_controller
//   Bit-serial add/subtract engine. One full_adder cell is reused across the
//   WIDTH-bit operands, LSB first, one bit per clock. Produces ARM-style NZCV
//   flags. Start/ready/done handshake; latency WIDTH+1 cycles to done.
//   Ports:
//     clk        - clock, rising edge
//     reset      - synchronous active-high reset
//     start      - request, accepted only while ready=1
//     sub        - 0: A+B, 1: A-B (sampled at accept)
//     A, B       - operands (sampled at accept)
//     ready      - high while idle
//     done       - one-cycle completion pulse
//     result     - registered sum/difference, held until next completion
//     negative   - result MSB
//     zero       - result == 0
//     carry_out  - carry out of MSB (1 = no borrow for subtract)
//     overflow   - signed overflow
// -----------------------------------------------------------------------------
module serial_adder_controller #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic             carry_reg;
   logic [CNT_W-1:0] count;

   logic             fa_s;
   logic             fa_cout;
   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] sum_next;

   full_adder fa (
      .A         (a_sh[0]),
      .B         (b_sh[0]),
      .carry_in  (carry_reg),
      .S         (fa_s),
      .carry_out (fa_cout)
   );

   // Sum shift register after this cycle's bit lands in the MSB; on the final
   // bit this is the complete result.
   always_comb begin
      sum_next = {fa_s, s_sh[WIDTH-1:1]};
      accept   = (state_q == IDLE) && start;
      last_bit = (state_q == RUN) && (count == LAST_BIT);
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and Moore outputs
   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (count == LAST_BIT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand/sum shifting, carry feedback and bit counter
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh      <= '0;
         b_sh      <= '0;
         s_sh      <= '0;
         carry_reg <= 1'b0;
         count     <= '0;
      end else if (accept) begin
         // Subtract as A + ~B + 1: the +1 enters through the initial carry.
         a_sh      <= A;
         b_sh      <= sub ? ~B : B;
         carry_reg <= sub;
         count     <= '0;
      end else if (state_q == RUN) begin
         s_sh      <= sum_next;
         a_sh      <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh      <= {1'b0, b_sh[WIDTH-1:1]};
         carry_reg <= fa_cout;
         count     <= count + 1'b1;
      end
   end

   // Result and flags update only on the final bit. At that point carry_reg
   // holds the carry into the MSB, so overflow is carry-in XOR carry-out.
   always_ff @(posedge clk) begin
      if (reset) begin
         result    <= '0;
         negative  <= 1'b0;
         zero      <= 1'b0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (last_bit) begin
         result    <= sum_next;
         negative  <= fa_s;
         zero      <= (sum_next == '0);
         carry_out <= fa_cout;
         overflow  <= carry_reg ^ fa_cout;
      end
   end

endmodule

// File: tb/tb_serial_adder_controller.sv
module tb_serial_adder_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // WIDTH=8 instance
   logic        r8, start8, sub8;
   logic [7:0]  a8, b8, res8;
   logic        rdy8, done8, n8, z8, c8, v8;

   // WIDTH=64 instance
   logic        r64, start64, sub64;
   logic [63:0] a64, b64, res64;
   logic        rdy64, done64, n64, z64, c64, v64;

   serial_adder_controller #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(r8), .start(start8), .sub(sub8), .A(a8), .B(b8),
      .ready(rdy8), .done(done8), .result(res8), .negative(n8), .zero(z8),
      .carry_out(c8), .overflow(v8)
   );

   serial_adder_controller #(.WIDTH(64)) dut64 (
      .clk(clk), .reset(r64), .start(start64), .sub(sub64), .A(a64), .B(b64),
      .ready(rdy64), .done(done64), .result(res64), .negative(n64), .zero(z64),
      .carry_out(c64), .overflow(v64)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after an edge with dut8 idle. Checks done lands in cycle 9,
   // ready returns in cycle 10.
   task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic en, input logic ez,
                       input logic ec, input logic ev);
      int cyc;
      start8 = 1'b1; sub8 = s; a8 = a; b8 = b;
      tick();
      start8 = 1'b0;
      cyc = 1;
      check({tag, "_busy"}, {63'd0, rdy8}, 64'd0);
      while (!done8 && cyc < 40) begin
         tick();
         cyc++;
      end
      check({tag, "_done_cycle"}, 64'(cyc), 64'd9);
      check({tag, "_result"}, {56'd0, res8}, {56'd0, er});
      check({tag, "_nzcv"}, {60'd0, n8, z8, c8, v8}, {60'd0, en, ez, ec, ev});
      tick();
      check({tag, "_ready_back"}, {62'd0, rdy8, done8}, 64'b10);
   endtask

   task automatic run64(input string tag, input logic s, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] er, input logic en, input logic ez,
                        input logic ec, input logic ev);
      int cyc;
      start64 = 1'b1; sub64 = s; a64 = a; b64 = b;
      tick();
      start64 = 1'b0;
      cyc = 1;
      while (!done64 && cyc < 200) begin
         tick();
         cyc++;
      end
      check({tag, "_done_cycle"}, 64'(cyc), 64'd65);
      check({tag, "_result"}, res64, er);
      check({tag, "_nzcv"}, {60'd0, n64, z64, c64, v64}, {60'd0, en, ez, ec, ev});
      tick();
      check({tag, "_ready_back"}, {63'd0, rdy64}, 64'd1);
   endtask

   initial begin
      int seen_done;

      // Reset held two cycles with start asserted: no accept.
      r8 = 1'b1; start8 = 1'b1; sub8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
      r64 = 1'b1; start64 = 1'b1; sub64 = 1'b0; a64 = 64'd7; b64 = 64'd9;
      tick();
      tick();
      check("rst8_ctrl", {62'd0, rdy8, done8}, 64'b10);
      check("rst8_result", {56'd0, res8}, 64'd0);
      check("rst8_flags", {60'd0, n8, z8, c8, v8}, 64'd0);
      check("rst64_ctrl", {62'd0, rdy64, done64}, 64'b10);
      check("rst64_result", res64, 64'd0);
      check("rst64_flags", {60'd0, n64, z64, c64, v64}, 64'd0);
      start8 = 1'b0; start64 = 1'b0;
      r8 = 1'b0; r64 = 1'b0;
      tick();
      check("post_rst_idle8", {63'd0, rdy8}, 64'd1);

      // WIDTH=8 directed vectors
      run8("add_5_3",   1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
      run8("add_7f_1",  1'b0, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
      run8("add_ff_1",  1'b0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      run8("sub_5_5",   1'b1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      run8("sub_3_5",   1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);

      // WIDTH=64 directed vectors
      run64("add64_max_1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,
            1'b0, 1'b1, 1'b1, 1'b0);
      run64("sub64_min_1", 1'b1, 64'h8000_0000_0000_0000, 64'd1,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);

      // Handshake: start held, operands churn during RUN. Prior result is
      // 0xFE from sub_3_5.
      start8 = 1'b1; sub8 = 1'b0; a8 = 8'h10; b8 = 8'h20;
      tick();                                  // edge 0 -> cycle 1
      for (int k = 1; k <= 7; k++) begin
         a8 = 8'(k * 37); b8 = 8'(k * 11); sub8 = k[0];
         tick();                               // ends in cycle k+1
         if (k == 4)
            check("hs_hold_prev", {56'd0, res8}, 64'h00FE);
      end
      sub8 = 1'b1; a8 = 8'h40; b8 = 8'h01;     // operands for second op
      tick();                                  // cycle 9
      check("hs_done1", {63'd0, done8}, 64'd1);
      check("hs_res1", {56'd0, res8}, 64'h0030);
      check("hs_flags1", {60'd0, n8, z8, c8, v8}, 64'd0);
      tick();                                  // cycle 10
      check("hs_ready_c10", {62'd0, rdy8, done8}, 64'b10);
      tick();                                  // edge 10 accepted -> cycle 11
      check("hs_accept2", {63'd0, rdy8}, 64'd0);
      start8 = 1'b0;
      for (int k = 0; k < 7; k++) begin
         a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0;
         tick();
      end
      check("hs_hold_res1", {56'd0, res8}, 64'h0030);
      seen_done = 0;
      for (int k = 0; k < 3 && seen_done == 0; k++) begin
         tick();
         if (done8) seen_done = 1;
      end
      check("hs_done2_seen", 64'(seen_done), 64'd1);
      check("hs_res2", {56'd0, res8}, 64'h003F);
      check("hs_flags2", {60'd0, n8, z8, c8, v8}, 64'b0010);
      tick();

      // Reset in RUN cycle 4 aborts; result cleared, no done.
      start8 = 1'b1; sub8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
      tick();                                  // cycle 1
      start8 = 1'b0;
      tick(); tick(); tick();                  // cycle 4
      r8 = 1'b1;
      tick();                                  // cycle 5
      r8 = 1'b0;
      check("abort_ctrl", {62'd0, rdy8, done8}, 64'b10);
      check("abort_result", {56'd0, res8}, 64'd0);
      check("abort_flags", {60'd0, n8, z8, c8, v8}, 64'd0);
      seen_done = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done8) seen_done = 1;
      end
      check("abort_no_done", 64'(seen_done), 64'd0);
      run8("after_abort", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_controller.md
# serial_adder_controller

Bit-serial add/subtract engine that time-multiplexes a single instance of the team's `full_adder` cell over a WIDTH-bit operand pair, one bit per clock. It sequences operand shifting, carry feedback and result assembly, and produces ARM-style NZCV flags. It sits beside the single-cycle datapath as a low-area arithmetic unit for multi-cycle or background operations. It uses a start/ready/done handshake.

## Interface
- `WIDTH`, default 64: operand and result width in bits (≥2).
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high; sampled on the `clk` rising edge.
- `start` input, 1 bit: request; accepted only on an edge where `ready`=1.
- `sub` input, 1 bit: 0 = A+B, 1 = A−B; sampled at accept only.
- `A` input, WIDTH bits: first operand; sampled at accept only.
- `B` input, WIDTH bits: second operand; sampled at accept only.
- `ready` output, 1 bit: high exactly while in IDLE.
- `done` output, 1 bit: one-cycle pulse; result and flags are valid from this cycle on.
- `result` output, WIDTH bits: registered sum/difference, held until the next completion.
- `negative` output, 1 bit: `result[WIDTH-1]`.
- `zero` output, 1 bit: `result`==0.
- `carry_out` output, 1 bit: carry out of the MSB. For subtract it is 1 = no borrow.
- `overflow` output, 1 bit: signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Exactly one `full_adder` instance; no other adder logic. Its inputs are `a_sh[0]`, `b_sh[0]` and the carry register.
- Internal state: FSM {IDLE, RUN, DONE}, `a_sh`/`b_sh`/`s_sh` WIDTH-bit shift registers, 1-bit carry register, bit counter of width $clog2(WIDTH).
- Accept (IDLE, `start`=1):
  - `a_sh`←A.
  - `b_sh`←(`sub` ? ~B : B).
  - carry←`sub`.
  - count←0.
  - Go to RUN.
- IDLE with `start`=0: hold all state.
- Each RUN cycle:
  - `s_sh`←{fa.S, `s_sh`[WIDTH-1:1]}.
  - `a_sh`, `b_sh` shift right by 1.
  - carry←fa.carry_out.
  - count←count+1.
- Final RUN cycle (count==WIDTH−1):
  - `result`←{fa.S, `s_sh`[WIDTH-1:1]}.
  - `carry_out`←fa.carry_out.
  - `overflow`←carry_reg XOR fa.carry_out.
  - `negative`←fa.S.
  - `zero`←(the final result value ==0).
  - Go to DONE.
- DONE: `done`=1 and `ready`=0 for one cycle, then unconditionally go to IDLE.
- `start` asserted in RUN or DONE is ignored and is not queued.
- Changes on A, B or `sub` after accept have no effect on the operation in flight.
- `result` and flags change only on the final-RUN edge. They hold their values through the next operation until that operation completes.
- Arithmetic is modulo 2^WIDTH. Unsigned and two's-complement results are identical; only the flags interpret them.

## Timing
- Reset (edge with `reset`=1), regardless of state:
  - FSM→IDLE; counter, shift registers and carry cleared.
  - `result`=0; `negative`, `zero`, `carry_out`, `overflow`=0.
  - `done`=0, `ready`=1.
  - Reset wins over a simultaneous `start`.
- Reset mid-RUN or in DONE aborts the operation. No `done` pulse follows, and `result` and flags read 0.
- Latency, with the accept edge = edge 0:
  - RUN occupies cycles 1..WIDTH.
  - `done`=1 in cycle WIDTH+1.
  - `ready`=1 again from cycle WIDTH+2.
  - Throughput: one operation per WIDTH+2 cycles.
- If `start` is held continuously, the next operation is accepted on the first edge where `ready`=1. This is the edge that ends cycle WIDTH+2.
- `ready` and `done` are decoded from the FSM state only (Moore); there is no combinational path from inputs to outputs.
- Clock period must exceed the `full_adder` worst-case combinational delay (3 gate delays) plus register setup.

## Test plan
- Reset: hold `reset` 2 cycles with `start`=1 -> `ready`=1, `done`=0, `result`=0, all flags 0, no accept.
- WIDTH=8, add 0x05+0x03 -> `done` exactly in cycle 9 after accept; `result`=0x08, N=0, Z=0, C=0, V=0. `ready`=1 in cycle 10.
- WIDTH=8, flags:
  - 0x7F+0x01 -> 0x80, N=1, V=1, C=0, Z=0.
  - 0xFF+0x01 -> 0x00, Z=1, C=1, V=0.
  - sub 0x05−0x05 -> 0x00, Z=1, C=1.
  - sub 0x03−0x05 -> 0xFE, N=1, C=0, V=0.
- WIDTH=64:
  - add 0xFFFF_FFFF_FFFF_FFFF+1 -> 0, C=1, Z=1, `done` in cycle 65.
  - sub 0x8000_0000_0000_0000−1 -> 0x7FFF_FFFF_FFFF_FFFF, V=1.
- Handshake: hold `start`=1 and change A/B every cycle during RUN -> result reflects only the operands at accept. The second op is accepted at the end of cycle WIDTH+2, and prior `result` is held until its completion.
- Reset in RUN cycle 4 -> IDLE next cycle, no `done` pulse, `result`=0. A new op after reset completes correctly.
